padc_conv_ctrl: RTL and testbench
=================================

PADC_CONV_CTRL -- requirements
Module: padc_conv_ctrl

Interface
REQ-001 Parameter FILL_LAT, default 7: pipeline fill latency in clk cycles, from adc_en rising to first valid corrected sample on adc_data.
REQ-002 Parameter DEPTH, default 4: output FIFO depth in entries, power of two, minimum 2.
REQ-003 clk  input  1  block clock; all state changes on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  burst request; sampled only in IDLE.
REQ-006 abort  input  1  terminates any burst; takes priority over every other input.
REQ-007 burst_len  input  8  number of samples to capture; unsigned; latched on accepted start.
REQ-008 adc_data  input  8  signed corrected sample from the digital correction stage, valid every cycle once filled.
REQ-009 out_ready  input  1  consumer ready.
REQ-010 adc_en  output  1  enables ADC sampling and conversion.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 out_valid  output  1  FIFO head valid.
REQ-013 out_data  output  8  signed FIFO head sample.
REQ-014 done  output  1  one-cycle pulse at end of burst.
REQ-015 overrun  output  1  sticky flag: at least one sample dropped in the current or last burst.

Function
REQ-016 FSM states: IDLE, FILL, STREAM, DRAIN; registered state; adc_en high exactly in FILL and STREAM.
REQ-017 IDLE: start=1 with burst_len>0 -> FILL next cycle; latch burst_len; clear overrun; reset fill and sample counters.
REQ-018 IDLE: start=1 with burst_len=0 -> stay IDLE, done=1 next cycle, adc_en stays 0, overrun cleared.
REQ-019 start outside IDLE ignored, no side effects.
REQ-020 FILL: fill counter counts 0..FILL_LAT-1; on final count -> STREAM; adc_data not captured in FILL.
REQ-021 STREAM: each cycle one push of adc_data; sample counter increments per push attempt, accepted or dropped.
REQ-022 STREAM: on attempt number burst_len -> DRAIN next cycle; adc_en low from DRAIN onward.
REQ-023 Push accepted when FIFO not full, or full with out_valid && out_ready in the same cycle; otherwise sample dropped, overrun set.
REQ-024 Pop on out_valid && out_ready; FIFO order preserved; out_data stable while out_valid && !out_ready.
REQ-025 out_valid = FIFO non-empty; out_data = head entry; both combinational from registered FIFO state.
REQ-026 A pushed sample is visible at out_data no earlier than the cycle after its push.
REQ-027 DRAIN: remains until FIFO empty; then IDLE with done=1 for exactly one cycle coincident with the first IDLE cycle.
REQ-028 abort=1 in any state -> IDLE next cycle; FIFO flushed; counters cleared; adc_en=0; no done pulse; overrun kept.
REQ-029 abort and start in the same IDLE cycle: abort wins, start is dropped.
REQ-030 Samples are stored unmodified; no arithmetic on adc_data.
REQ-031 FIFO pointers wrap modulo DEPTH; occupancy count is DEPTH+1 states wide; no overflow or underflow of the count.

Reset
REQ-032 While rstn=0: state IDLE, adc_en=0, busy=0, out_valid=0, out_data=0, done=0, overrun=0, FIFO empty, all counters 0.
REQ-033 Reset asserted mid-burst behaves as REQ-032 immediately; first start after release is accepted normally.

Verification
REQ-034 Basic: burst_len=5, out_ready=1, adc_data ramp 1,2,3,... from adc_en rise.
  - adc_en high for 7+5 cycles.
  - Outputs are the 5 samples that follow the 7 FILL cycles, in order.
  - done pulses once; overrun=0.
REQ-035 Backpressure: burst_len=10, out_ready=0 throughout STREAM.
  - First 4 samples retained; 6 dropped; overrun=1.
  - DRAIN holds until out_ready=1 pops all 4; then done.
REQ-036 Full-with-pop: FIFO full, out_ready=1 in a STREAM cycle.
  - Push accepted, occupancy stays 4, no overrun.
REQ-037 Zero-length burst: burst_len=0, start=1.
  - adc_en never rises; done=1 on the next cycle; busy stays 0.
REQ-038 Abort: abort=1 at the 3rd STREAM cycle.
  - IDLE next cycle, out_valid=0, no done pulse.
  - A new start with burst_len=2 then completes normally.
REQ-039 Reset mid-DRAIN with 2 samples queued.
  - All outputs per REQ-032 during reset.
  - No stale data after release.

Source files
------------

// File: rtl/padc_conv_ctrl.sv
`default_nettype none
// ============================================================================
// padc_conv_ctrl : ADC burst capture controller with an output sample FIFO
// Rev 1.0
// ============================================================================
module padc_conv_ctrl #(
    parameter int FILL_LAT = 7,
    parameter int DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [7:0] burst_len_i,
    input  logic [7:0] adc_data_i,
    input  logic       out_ready_i,
    output logic       adc_en_o,
    output logic       busy_o,
    output logic       out_valid_o,
    output logic [7:0] out_data_o,
    output logic       done_o,
    output logic       overrun_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = (FILL_LAT > 1) ? $clog2(FILL_LAT) : 1;
    localparam logic [FW-1:0] FILL_LAST = FW'(FILL_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] fill_cnt_q, fill_cnt_d;
    logic [7:0]    samp_cnt_q, samp_cnt_d;
    logic [7:0]    len_q, len_d;
    logic          overrun_q, overrun_d;
    logic          done_q, done_d;

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [7:0]    mem_q [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drain_empty;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == CW'(DEPTH));
    assign w_pop   = !w_empty && out_ready_i;
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign w_push  = (state_q == STREAM) && !abort_i && (!w_full || w_pop);
    assign w_drain_empty = w_empty || ((count_q == CW'(1)) && w_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            fill_cnt_q <= '0;
            samp_cnt_q <= '0;
            len_q      <= '0;
            overrun_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            len_q      <= len_d;
            overrun_q  <= overrun_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        samp_cnt_d = samp_cnt_q;
        len_d      = len_q;
        overrun_d  = overrun_q;
        done_d     = 1'b0;
        if (abort_i) begin
            state_d    = IDLE;
            fill_cnt_d = '0;
            samp_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        overrun_d  = 1'b0;
                        fill_cnt_d = '0;
                        samp_cnt_d = '0;
                        if (burst_len_i == 8'd0) begin
                            done_d = 1'b1;
                        end else begin
                            len_d   = burst_len_i;
                            state_d = FILL;
                        end
                    end
                end
                FILL: begin
                    if (fill_cnt_q == FILL_LAST) begin
                        fill_cnt_d = '0;
                        state_d    = STREAM;
                    end else begin
                        fill_cnt_d = fill_cnt_q + FW'(1);
                    end
                end
                STREAM: begin
                    if (!w_push) begin
                        overrun_d = 1'b1;
                    end
                    samp_cnt_d = samp_cnt_q + 8'd1;
                    if (samp_cnt_q == len_q - 8'd1) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_drain_empty) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (abort_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= adc_data_i;
        end
    end

    assign adc_en_o    = (state_q == FILL) || (state_q == STREAM);
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = !w_empty;
    assign out_data_o  = w_empty ? 8'd0 : mem_q[rd_ptr_q];
    assign done_o      = done_q;
    assign overrun_o   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_padc_conv_ctrl.sv
`default_nettype none
// Directed self-checking bench for padc_conv_ctrl (FILL_LAT=7, DEPTH=4).
module tb_padc_conv_ctrl;

    logic       clk;
    logic       rstn;
    logic       start_s;
    logic       abort_s;
    logic [7:0] burst_len_s;
    logic [7:0] adc_data_s;
    logic       out_ready_s;
    logic       adc_en_o;
    logic       busy_o;
    logic       out_valid_o;
    logic [7:0] out_data_o;
    logic       done_o;
    logic       overrun_o;

    int n_chk  = 0;
    int n_fail = 0;

    int        en_cnt, done_cnt, done_c, first_en_c;
    logic      snap_busy, snap_en, snap_valid, snap_done, snap_ovr, pre_valid;
    logic [7:0] samples[$];
    int        ramp;

    padc_conv_ctrl #(.FILL_LAT(7), .DEPTH(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start_i     (start_s),
        .abort_i     (abort_s),
        .burst_len_i (burst_len_s),
        .adc_data_i  (adc_data_s),
        .out_ready_i (out_ready_s),
        .adc_en_o    (adc_en_o),
        .busy_o      (busy_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .done_o      (done_o),
        .overrun_o   (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ramp 1,2,3,... starting in the first cycle adc_en is high.
    initial begin
        adc_data_s = 8'd0;
        ramp = 1;
        forever begin
            @(posedge clk);
            #1;
            if (adc_en_o) begin
                adc_data_s = 8'(ramp);
                ramp++;
            end else begin
                adc_data_s = 8'd0;
                ramp = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle c is the c-th cycle after the start edge; out_ready is high from cycle ready_c.
    task automatic run_burst(input logic [7:0] len, input int ready_c, input int abort_c,
                             input int snap_c, input int max_c);
        samples.delete();
        en_cnt = 0; done_cnt = 0; done_c = 0; first_en_c = 0;
        start_s     = 1'b1;
        burst_len_s = len;
        out_ready_s = (ready_c <= 0);
        tick();
        start_s = 1'b0;
        for (int c = 1; c <= max_c; c++) begin
            abort_s     = (c == abort_c);
            out_ready_s = (c >= ready_c);
            if (adc_en_o) begin
                en_cnt++;
                if (first_en_c == 0) first_en_c = c;
            end
            if (done_o) begin
                done_cnt++;
                if (done_c == 0) done_c = c;
            end
            if (c == abort_c) pre_valid = out_valid_o;
            if (c == snap_c) begin
                snap_busy  = busy_o;
                snap_en    = adc_en_o;
                snap_valid = out_valid_o;
                snap_done  = done_o;
                snap_ovr   = overrun_o;
            end
            if (out_valid_o && out_ready_s) samples.push_back(out_data_o);
            if (done_o || (abort_c > 0 && c == abort_c + 3)) break;
            tick();
        end
        abort_s = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        n_chk++; if (adc_en_o !== 1'b0)    begin n_fail++; $display("FAIL reset_adc_en: got %b, expected 0", adc_en_o); end
        n_chk++; if (busy_o !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy_o); end
        n_chk++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid_o); end
        n_chk++; if (out_data_o !== 8'd0)  begin n_fail++; $display("FAIL reset_out_data: got %0d, expected 0", out_data_o); end
        n_chk++; if (done_o !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done_o); end
        n_chk++; if (overrun_o !== 1'b0)   begin n_fail++; $display("FAIL reset_overrun: got %b, expected 0", overrun_o); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        run_burst(8'd5, 0, 0, 0, 40);
        n_chk++; if (first_en_c !== 1) begin n_fail++; $display("FAIL basic_en_rise: got cycle %0d, expected 1", first_en_c); end
        n_chk++; if (en_cnt !== 12)    begin n_fail++; $display("FAIL basic_en_cycles: got %0d, expected 12", en_cnt); end
        n_chk++; if (samples.size() !== 5) begin n_fail++; $display("FAIL basic_count: got %0d, expected 5", samples.size()); end
        for (int i = 0; i < 5 && i < samples.size(); i++) begin
            n_chk++;
            if (samples[i] !== 8'(8 + i)) begin
                n_fail++; $display("FAIL basic_sample[%0d]: got %0d, expected %0d", i, samples[i], 8 + i);
            end
        end
        n_chk++; if (done_c !== 14)    begin n_fail++; $display("FAIL basic_done_cycle: got %0d, expected 14", done_c); end
        n_chk++; if (done_cnt !== 1)   begin n_fail++; $display("FAIL basic_done_count: got %0d, expected 1", done_cnt); end
        n_chk++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL basic_overrun: got %b, expected 0", overrun_o); end
        n_chk++; if (busy_o !== 1'b0)  begin n_fail++; $display("FAIL basic_busy_end: got %b, expected 0", busy_o); end
        tick();
        n_chk++; if (done_o !== 1'b0)  begin n_fail++; $display("FAIL basic_done_pulse: got %b, expected 0", done_o); end
    endtask

    task automatic test_backpressure();
        run_burst(8'd10, 22, 0, 20, 60);
        n_chk++; if (snap_busy !== 1'b1)  begin n_fail++; $display("FAIL bp_drain_busy: got %b, expected 1", snap_busy); end
        n_chk++; if (snap_en !== 1'b0)    begin n_fail++; $display("FAIL bp_drain_adc_en: got %b, expected 0", snap_en); end
        n_chk++; if (snap_valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain_valid: got %b, expected 1", snap_valid); end
        n_chk++; if (snap_done !== 1'b0)  begin n_fail++; $display("FAIL bp_drain_done: got %b, expected 0", snap_done); end
        n_chk++; if (snap_ovr !== 1'b1)   begin n_fail++; $display("FAIL bp_drain_overrun: got %b, expected 1", snap_ovr); end
        n_chk++; if (samples.size() !== 4) begin n_fail++; $display("FAIL bp_count: got %0d, expected 4", samples.size()); end
        for (int i = 0; i < 4 && i < samples.size(); i++) begin
            n_chk++;
            if (samples[i] !== 8'(8 + i)) begin
                n_fail++; $display("FAIL bp_sample[%0d]: got %0d, expected %0d", i, samples[i], 8 + i);
            end
        end
        n_chk++; if (en_cnt !== 17)  begin n_fail++; $display("FAIL bp_en_cycles: got %0d, expected 17", en_cnt); end
        n_chk++; if (done_c !== 26)  begin n_fail++; $display("FAIL bp_done_cycle: got %0d, expected 26", done_c); end
        n_chk++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL bp_overrun_sticky: got %b, expected 1", overrun_o); end
        tick();
    endtask

    task automatic test_zero_len();
        n_chk++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL zl_overrun_before: got %b, expected 1", overrun_o); end
        run_burst(8'd0, 0, 0, 1, 5);
        n_chk++; if (done_c !== 1)    begin n_fail++; $display("FAIL zl_done_cycle: got %0d, expected 1", done_c); end
        n_chk++; if (snap_busy !== 1'b0) begin n_fail++; $display("FAIL zl_busy: got %b, expected 0", snap_busy); end
        n_chk++; if (en_cnt !== 0)    begin n_fail++; $display("FAIL zl_adc_en: got %0d cycles, expected 0", en_cnt); end
        n_chk++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL zl_overrun_clear: got %b, expected 0", overrun_o); end
        tick();
        n_chk++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL zl_done_pulse: got %b, expected 0", done_o); end
        n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL zl_busy_after: got %b, expected 0", busy_o); end
    endtask

    task automatic test_full_pop();
        run_burst(8'd6, 12, 0, 0, 40);
        n_chk++; if (samples.size() !== 6) begin n_fail++; $display("FAIL fp_count: got %0d, expected 6", samples.size()); end
        for (int i = 0; i < 6 && i < samples.size(); i++) begin
            n_chk++;
            if (samples[i] !== 8'(8 + i)) begin
                n_fail++; $display("FAIL fp_sample[%0d]: got %0d, expected %0d", i, samples[i], 8 + i);
            end
        end
        n_chk++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL fp_overrun: got %b, expected 0", overrun_o); end
        n_chk++; if (done_c !== 18)  begin n_fail++; $display("FAIL fp_done_cycle: got %0d, expected 18", done_c); end
        tick();
    endtask

    task automatic test_abort();
        run_burst(8'd8, 999, 10, 11, 30);
        n_chk++; if (pre_valid !== 1'b1)  begin n_fail++; $display("FAIL ab_pre_valid: got %b, expected 1", pre_valid); end
        n_chk++; if (snap_busy !== 1'b0)  begin n_fail++; $display("FAIL ab_busy: got %b, expected 0", snap_busy); end
        n_chk++; if (snap_en !== 1'b0)    begin n_fail++; $display("FAIL ab_adc_en: got %b, expected 0", snap_en); end
        n_chk++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL ab_out_valid: got %b, expected 0", snap_valid); end
        n_chk++; if (done_cnt !== 0)      begin n_fail++; $display("FAIL ab_no_done: got %0d, expected 0", done_cnt); end
        run_burst(8'd2, 0, 0, 0, 30);
        n_chk++; if (samples.size() !== 2) begin n_fail++; $display("FAIL ab_new_count: got %0d, expected 2", samples.size()); end
        for (int i = 0; i < 2 && i < samples.size(); i++) begin
            n_chk++;
            if (samples[i] !== 8'(8 + i)) begin
                n_fail++; $display("FAIL ab_new_sample[%0d]: got %0d, expected %0d", i, samples[i], 8 + i);
            end
        end
        n_chk++; if (done_c !== 11) begin n_fail++; $display("FAIL ab_new_done_cycle: got %0d, expected 11", done_c); end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        run_burst(8'd2, 999, 0, 0, 12);
        n_chk++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL rd_queued_valid: got %b, expected 1", out_valid_o); end
        n_chk++; if (busy_o !== 1'b1)      begin n_fail++; $display("FAIL rd_queued_busy: got %b, expected 1", busy_o); end
        rstn = 1'b0;
        #1;
        n_chk++; if (busy_o !== 1'b0)      begin n_fail++; $display("FAIL rd_rst_busy: got %b, expected 0", busy_o); end
        n_chk++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rd_rst_valid: got %b, expected 0", out_valid_o); end
        n_chk++; if (out_data_o !== 8'd0)  begin n_fail++; $display("FAIL rd_rst_data: got %0d, expected 0", out_data_o); end
        n_chk++; if (adc_en_o !== 1'b0)    begin n_fail++; $display("FAIL rd_rst_adc_en: got %b, expected 0", adc_en_o); end
        n_chk++; if (done_o !== 1'b0)      begin n_fail++; $display("FAIL rd_rst_done: got %b, expected 0", done_o); end
        n_chk++; if (overrun_o !== 1'b0)   begin n_fail++; $display("FAIL rd_rst_overrun: got %b, expected 0", overrun_o); end
        tick();
        rstn = 1'b1;
        tick();
        n_chk++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rd_post_valid: got %b, expected 0", out_valid_o); end
        n_chk++; if (out_data_o !== 8'd0)  begin n_fail++; $display("FAIL rd_post_data: got %0d, expected 0", out_data_o); end
        run_burst(8'd1, 0, 0, 0, 30);
        n_chk++; if (samples.size() !== 1) begin n_fail++; $display("FAIL rd_new_count: got %0d, expected 1", samples.size()); end
        if (samples.size() > 0) begin
            n_chk++; if (samples[0] !== 8'd8) begin n_fail++; $display("FAIL rd_new_sample: got %0d, expected 8", samples[0]); end
        end
        n_chk++; if (done_c !== 10) begin n_fail++; $display("FAIL rd_new_done_cycle: got %0d, expected 10", done_c); end
        tick();
    endtask

    initial begin
        rstn        = 1'b0;
        start_s     = 1'b0;
        abort_s     = 1'b0;
        burst_len_s = 8'd0;
        out_ready_s = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_full_pop();
        test_abort();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
